mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one single-port memory between the Cpu instruction-fetch port and data port.
//   - Accepts at most one request at a time over valid/ready handshakes.
//   - Drives the memory strobes for a fixed latency, then returns read data or a write
//     acknowledgement to the granted requester.
//   - Sits between Cpu and Memory, replacing their direct instr/data wiring.
// PARAMETERS
//   ADDR_W       32  address width of both requester ports and memory port
//   DATA_W       32  data width
//   MEM_LATENCY  1   cycles mem_read/mem_write are held per access; legal range 1..15
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst          in   1       asynchronous, active-low reset
//   if_valid     in   1       fetch request valid
//   if_ready     out  1       fetch request accepted this cycle
//   if_addr      in   ADDR_W  fetch address
//   if_rvalid    out  1       one-cycle pulse: if_rdata valid
//   if_rdata     out  DATA_W  fetched instruction
//   d_valid      in   1       data request valid
//   d_ready      out  1       data request accepted this cycle
//   d_we         in   1       1 = store, 0 = load
//   d_addr       in   ADDR_W  data address
//   d_wdata      in   DATA_W  store data
//   d_rvalid     out  1       one-cycle pulse: load data valid, or store completed
//   d_rdata      out  DATA_W  load data; holds the last captured value on stores
//   mem_addr     out  ADDR_W  memory address
//   mem_wdata    out  DATA_W  memory write data
//   mem_rdata    in   DATA_W  memory read data
//   mem_read     out  1       memory read strobe
//   mem_write    out  1       memory write strobe
// BEHAVIOUR
//   - Reset (rst=0):
//     - State IDLE; all outputs 0; latency counter 0; last_grant = DATA.
//     - An in-flight access is dropped: no rvalid pulse, strobes drop immediately.
//   - FSM states: IDLE -> BUSY -> RESP -> IDLE.
//   - IDLE:
//     - Picker selects a winner among asserted valids; only the winner's ready is high,
//       combinationally.
//     - On valid&ready: latch addr, we and wdata; grant = winner; counter = MEM_LATENCY-1;
//       go to BUSY.
//   - BUSY:
//     - mem_addr = latched addr.
//     - mem_read = !we; mem_write = we; mem_wdata = latched wdata.
//     - Counter decrements each cycle.
//     - At counter==0, on a read, mem_rdata is registered into the granted rdata.
//     - Then go to RESP.
//   - RESP:
//     - Strobes 0; granted rvalid = 1 for exactly one cycle; both readys 0.
//     - Go to IDLE.
//   - Timing:
//     - Latency: accept in cycle 0; rvalid in cycle MEM_LATENCY+1.
//     - Peak throughput: one access per MEM_LATENCY+2 cycles.
//   - Handshake rules:
//     - Requesters hold valid and payload until ready.
//     - The arbiter samples the payload only in the accept cycle.
//     - A valid dropped before ready is legal and ignored.
//   - Idle memory bus: mem_addr and mem_wdata hold their last values; strobes are never
//     both high.
//   - rdata registers change only on a read completion for that port.
//   - Neither port ever sees rvalid without a prior accept.
// CONFIGURATION
//   ARB_RR_EN defined:
//     - When both valids are high in IDLE, grant the port not in last_grant (round-robin).
//     - last_grant updates on every accept.
//   ARB_RR_EN undefined:
//     - Fixed priority: data always wins over fetch.
//     - last_grant is still tracked but unused.
// STRUCTURE
//   - mem_arb_pkg: state enum {IDLE,BUSY,RESP}; grant enum {GNT_IF,GNT_D};
//     latency-counter width constant (4).
//   - Sub-module mem_arb_pick: combinational winner select from if_valid, d_valid and
//     last_grant, including the ARB_RR_EN choice.
// TESTING
//   - Reset: assert rst=0 mid-BUSY (MEM_LATENCY=3). Required: strobes 0 at once, no
//     rvalid, next accept works normally.
//   - Fetch only: if_addr=0x40, mem_rdata=0x8C220004, MEM_LATENCY=1. Required: if_ready at
//     cycle 0, mem_read cycle 1, if_rvalid with if_rdata=0x8C220004 at cycle 2.
//   - Store: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF. Required: mem_write=1 with those
//     values for MEM_LATENCY cycles, d_rvalid pulse, d_rdata unchanged.
//   - Contention, ARB_RR_EN off: both valids held for 3 accesses. Required: data granted
//     3 times, fetch starved while d_valid is high.
//   - Contention, ARB_RR_EN on: both valids held, last_grant=DATA after reset. Required:
//     grants IF, D, IF, D.
//   - Latency sweep MEM_LATENCY=1,4,15: back-to-back loads. Required: rvalid exactly
//     L+1 cycles after accept, accepts spaced L+2 cycles apart.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant ids, counter width.
// No logic. ARB_RR_EN (round-robin picker) is consumed in mem_arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    // Holds MEM_LATENCY-1 for latencies up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational winner select between fetch and data requests (ARB_RR_EN = round-robin).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller only honours the winner while idle.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_valid,
    input  logic   d_valid,
    input  grant_t last_grant,
    output logic   win_vld,
    output grant_t winner
);

`ifdef ARB_RR_EN
    always_comb begin
        win_vld = if_valid | d_valid;
        winner  = d_valid ? GNT_D : GNT_IF;
        if (if_valid && d_valid) begin
            winner = (last_grant == GNT_D) ? GNT_IF : GNT_D;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Data port has fixed priority over fetch.
    always_comb begin
        win_vld = if_valid | d_valid;
        winner  = d_valid ? GNT_D : GNT_IF;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between fetch and data ports (ARB_RR_EN selects round-robin).
// Latency: accept in cycle 0, strobes for MEM_LATENCY cycles, rvalid pulse at cycle MEM_LATENCY+1.
// Backpressure: one access in flight; both readys stay low until the response pulse has been sent.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1    // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    grant_t            grant_q, grant_d;
    grant_t            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic   win_vld;
    grant_t winner;

    mem_arb_pick u_pick (
        .if_valid   (if_valid),
        .d_valid    (d_valid),
        .last_grant (last_grant_q),
        .win_vld    (win_vld),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IF;
            last_grant_q <= GNT_D;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready     = 1'b0;
        d_ready      = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;

        case (state_q)
            IDLE: begin
                if_ready = win_vld && (winner == GNT_IF);
                d_ready  = win_vld && (winner == GNT_D);
                if (win_vld) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = CNT_INIT;
                    state_d      = BUSY;
                    if (winner == GNT_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        // Fetches never write; wdata keeps its last value on the idle bus.
                        addr_d = if_addr;
                        we_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                mem_read  = !we_q;
                mem_write = we_q;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = RESP;
                    if (!we_q) begin
                        if (grant_q == GNT_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                if_rvalid = (grant_q == GNT_IF);
                d_rvalid  = (grant_q == GNT_D);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (MEM_LATENCY 1,3,4,15) driven in parallel and
// compared every cycle against a transaction-level model; ARB_RR_EN selects the grant rule.
module tb_mem_arbiter;

    localparam int NI = 4;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    logic          clk;
    logic          rst;
    logic [NI-1:0] if_valid, if_ready, if_rvalid;
    logic [NI-1:0] d_valid, d_ready, d_we, d_rvalid;
    logic [NI-1:0] mem_read, mem_write;
    logic [31:0]   if_addr   [NI];
    logic [31:0]   if_rdata  [NI];
    logic [31:0]   d_addr    [NI];
    logic [31:0]   d_wdata   [NI];
    logic [31:0]   d_rdata   [NI];
    logic [31:0]   mem_addr  [NI];
    logic [31:0]   mem_wdata [NI];
    logic [31:0]   mem_rdata [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        mem_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LATENCY (lat_of(gi))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_valid  (if_valid[gi]),
            .if_ready  (if_ready[gi]),
            .if_addr   (if_addr[gi]),
            .if_rvalid (if_rvalid[gi]),
            .if_rdata  (if_rdata[gi]),
            .d_valid   (d_valid[gi]),
            .d_ready   (d_ready[gi]),
            .d_we      (d_we[gi]),
            .d_addr    (d_addr[gi]),
            .d_wdata   (d_wdata[gi]),
            .d_rvalid  (d_rvalid[gi]),
            .d_rdata   (d_rdata[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_rdata (mem_rdata[gi]),
            .mem_read  (mem_read[gi]),
            .mem_write (mem_write[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Grant rule written from the arbitration policy: 1 = data port wins.
    function automatic bit pick_d(input bit ifv, input bit dv, input bit last_d);
`ifdef ARB_RR_EN
        if (ifv && dv) return !last_d;
`endif
        return dv;
    endfunction

    // Transaction-level model: one access at a time, described by its accept cycle.
    int          cyc = 0;
    int          m_acc    [NI];
    int          m_free   [NI];
    bit          m_port_d [NI];
    bit          m_we     [NI];
    bit          m_last_d [NI];
    logic [31:0] m_addr   [NI];
    logic [31:0] m_wdata  [NI];
    logic [31:0] m_if_rd  [NI];
    logic [31:0] m_d_rd   [NI];
    bit          if_took  [NI];
    bit          d_took   [NI];
    int          gnt_n    [NI];
    bit          gnt_log  [NI][8];
    int          last_acc [NI];
    int          wr_cnt   [NI];
    int          drv_cnt  [NI];
    bit          sweep_on = 0;
    bit          rdata_fixed = 0;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) mem_rdata[k] = rdata_fixed ? 32'h8C22_0004 : $urandom;
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin : mon
            int L;
            bit idle, busy, resp, wd;
            L = lat_of(k);
            if (!rst) begin
                m_acc[k] = -1; m_free[k] = 0; m_last_d[k] = 1'b1;
                m_if_rd[k] = '0; m_d_rd[k] = '0;
                if_took[k] = 1'b0; d_took[k] = 1'b0;
            end else begin
                idle = (cyc >= m_free[k]);
                wd   = pick_d(if_valid[k], d_valid[k], m_last_d[k]);
                busy = (m_acc[k] >= 0) && (cyc > m_acc[k]) && (cyc <= m_acc[k] + L);
                resp = (m_acc[k] >= 0) && (cyc == m_acc[k] + L + 1);
                check($sformatf("if_ready[%0d]", k), 32'(if_ready[k]), 32'(idle && if_valid[k] && !wd));
                check($sformatf("d_ready[%0d]", k), 32'(d_ready[k]), 32'(idle && d_valid[k] && wd));
                check($sformatf("mem_read[%0d]", k), 32'(mem_read[k]), 32'(busy && !m_we[k]));
                check($sformatf("mem_write[%0d]", k), 32'(mem_write[k]), 32'(busy && m_we[k]));
                if (busy) check($sformatf("mem_addr[%0d]", k), mem_addr[k], m_addr[k]);
                if (busy && m_we[k]) check($sformatf("mem_wdata[%0d]", k), mem_wdata[k], m_wdata[k]);
                check($sformatf("if_rvalid[%0d]", k), 32'(if_rvalid[k]), 32'(resp && !m_port_d[k]));
                check($sformatf("d_rvalid[%0d]", k), 32'(d_rvalid[k]), 32'(resp && m_port_d[k]));
                check($sformatf("if_rdata[%0d]", k), if_rdata[k], m_if_rd[k]);
                check($sformatf("d_rdata[%0d]", k), d_rdata[k], m_d_rd[k]);
                if (mem_write[k] && mem_addr[k] == 32'h100 && mem_wdata[k] == 32'hDEAD_BEEF) wr_cnt[k]++;
                if (d_rvalid[k]) drv_cnt[k]++;
                // Read data is sampled on the last strobe cycle and visible from the next one.
                if (m_acc[k] >= 0 && cyc == m_acc[k] + L && !m_we[k]) begin
                    if (m_port_d[k]) m_d_rd[k] = mem_rdata[k];
                    else             m_if_rd[k] = mem_rdata[k];
                end
                if_took[k] = if_valid[k] && if_ready[k];
                d_took[k]  = d_valid[k] && d_ready[k];
                if (idle && (if_valid[k] || d_valid[k])) begin
                    if (sweep_on && last_acc[k] >= 0)
                        check($sformatf("spacing[%0d]", k), 32'(cyc - last_acc[k]), 32'(L + 2));
                    last_acc[k] = cyc;
                    m_acc[k]    = cyc;
                    m_free[k]   = cyc + L + 2;
                    m_port_d[k] = wd;
                    m_last_d[k] = wd;
                    m_we[k]     = wd ? d_we[k] : 1'b0;
                    m_addr[k]   = wd ? d_addr[k] : if_addr[k];
                    m_wdata[k]  = d_wdata[k];
                    if (gnt_n[k] < 8) gnt_log[k][gnt_n[k]] = wd;
                    gnt_n[k]++;
                end
            end
        end
        cyc++;
    end

    task automatic clear_reqs();
        if_valid = '0; d_valid = '0; d_we = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_if_ready[%0d]", k), 32'(if_ready[k]), 32'd0);
            check($sformatf("rst_d_ready[%0d]", k), 32'(d_ready[k]), 32'd0);
            check($sformatf("rst_strobes[%0d]", k), 32'({mem_read[k], mem_write[k]}), 32'd0);
            check($sformatf("rst_rvalids[%0d]", k), 32'({if_rvalid[k], d_rvalid[k]}), 32'd0);
            check($sformatf("rst_if_rdata[%0d]", k), if_rdata[k], 32'd0);
            check($sformatf("rst_d_rdata[%0d]", k), d_rdata[k], 32'd0);
            check($sformatf("rst_mem_addr[%0d]", k), mem_addr[k], 32'd0);
            check($sformatf("rst_mem_wdata[%0d]", k), mem_wdata[k], 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        clear_reqs();
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        bit done;
        logic [31:0] saved_d [NI];
        rst = 1'b0;
        clear_reqs();
        for (int k = 0; k < NI; k++) begin
            if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; mem_rdata[k] = '0;
            last_acc[k] = -1; gnt_n[k] = 0; wr_cnt[k] = 0; drv_cnt[k] = 0;
        end
        do_reset();

        // Directed fetch on the MEM_LATENCY=1 instance.
        @(posedge clk); #1;
        rdata_fixed = 1'b1;
        if_valid = '1;
        for (int k = 0; k < NI; k++) if_addr[k] = 32'h40;
        @(negedge clk);
        check("fetch_ready_c0", 32'(if_ready[0]), 32'd1);
        @(posedge clk); #1;
        if_valid = '0;
        @(negedge clk);
        check("fetch_read_c1", 32'(mem_read[0]), 32'd1);
        check("fetch_addr_c1", mem_addr[0], 32'h40);
        @(negedge clk);
        check("fetch_rvalid_c2", 32'(if_rvalid[0]), 32'd1);
        check("fetch_rdata_c2", if_rdata[0], 32'h8C22_0004);
        idle_cycles(20);
        rdata_fixed = 1'b0;

        // Directed store: strobe count, single response, load data untouched.
        for (int k = 0; k < NI; k++) begin
            wr_cnt[k] = 0; drv_cnt[k] = 0; saved_d[k] = m_d_rd[k];
            d_addr[k] = 32'h100; d_wdata[k] = 32'hDEAD_BEEF;
        end
        d_valid = '1; d_we = '1;
        @(posedge clk); #1;
        clear_reqs();
        idle_cycles(20);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("store_wr_cycles[%0d]", k), 32'(wr_cnt[k]), 32'(lat_of(k)));
            check($sformatf("store_rvalid_cnt[%0d]", k), 32'(drv_cnt[k]), 32'd1);
            check($sformatf("store_d_rdata[%0d]", k), d_rdata[k], saved_d[k]);
        end

        // Reset while the load is still in BUSY.
        for (int k = 0; k < NI; k++) d_addr[k] = $urandom;
        d_valid = '1;
        @(posedge clk); #1;
        clear_reqs();
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("midrst_strobes[%0d]", k), 32'({mem_read[k], mem_write[k]}), 32'd0);
            check($sformatf("midrst_rvalid[%0d]", k), 32'({if_rvalid[k], d_rvalid[k]}), 32'd0);
        end
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++)
                check($sformatf("midrst_hold_rvalid[%0d]", k), 32'({if_rvalid[k], d_rvalid[k]}), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) d_addr[k] = $urandom;
        d_valid = '1;
        for (int n = 0; n <= lat_of(1) + 1; n++) begin
            @(negedge clk);
            check($sformatf("post_rst_rvalid_c%0d", n), 32'(d_rvalid[1]), 32'(n == lat_of(1) + 1));
            if (n == 0) begin
                @(posedge clk); #1;
                clear_reqs();
            end
        end
        idle_cycles(20);

        // Contention with both valids held continuously.
        do_reset();
        for (int k = 0; k < NI; k++) gnt_n[k] = 0;
        if_valid = '1; d_valid = '1; d_we = '0;
        t = 0;
        done = 1'b0;
        while (!done && t < 300) begin
            @(posedge clk); #1;
            t++;
            done = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (if_took[k]) if_addr[k] = $urandom;
                if (d_took[k])  d_addr[k]  = $urandom;
                if (gnt_n[k] < 4) done = 1'b0;
            end
        end
        clear_reqs();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("cont_count[%0d]", k), 32'(gnt_n[k] >= 4), 32'd1);
            for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
                check($sformatf("cont_rr[%0d][%0d]", k, g), 32'(gnt_log[k][g]), 32'(g % 2));
`else
                check($sformatf("cont_fixed[%0d][%0d]", k, g), 32'(gnt_log[k][g]), 32'd1);
`endif
            end
        end
        idle_cycles(20);

        // Back-to-back loads: accept spacing checked by the monitor.
        for (int k = 0; k < NI; k++) last_acc[k] = -1;
        sweep_on = 1'b1;
        d_valid = '1; d_we = '0;
        repeat (120) begin
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) if (d_took[k]) d_addr[k] = $urandom;
        end
        sweep_on = 1'b0;
        idle_cycles(20);

        // Randomised traffic, including requests withdrawn before acceptance.
        repeat (1500) begin
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) begin
                if (if_valid[k] && !if_took[k]) begin
                    if ($urandom_range(15) == 0) if_valid[k] = 1'b0;
                end else begin
                    if_valid[k] = ($urandom_range(2) == 0);
                    if_addr[k]  = $urandom;
                end
                if (d_valid[k] && !d_took[k]) begin
                    if ($urandom_range(15) == 0) d_valid[k] = 1'b0;
                end else begin
                    d_valid[k] = ($urandom_range(2) == 0);
                    d_we[k]    = $urandom_range(1);
                    d_addr[k]  = $urandom;
                    d_wdata[k] = $urandom;
                end
            end
        end
        idle_cycles(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
